// File: rtl/seed_pkg.sv
// Shared constants, state encoding and the G function for the SEED decryption core.
// The S-boxes are stored as byte tables. Byte-wise masking rebuilds the SS0..SS3 words.
package seed_pkg;

    localparam int unsigned NumRounds = 16;
    localparam int unsigned KeyIdxW   = 4;
    localparam int unsigned BlockW    = 128;
    localparam int unsigned HalfW     = 64;
    localparam int unsigned WordW     = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seed_state_e;

    localparam logic [7:0] SBox1 [256] = '{
        8'hA9, 8'h85, 8'hD6, 8'hD3, 8'h54, 8'h1D, 8'hAC, 8'h25,
        8'h5D, 8'h43, 8'h18, 8'h1E, 8'h51, 8'hFC, 8'hCA, 8'h63,
        8'h28, 8'h44, 8'h20, 8'h9D, 8'hE0, 8'hE2, 8'hC8, 8'h17,
        8'hA5, 8'h8F, 8'h03, 8'h7B, 8'hBB, 8'h13, 8'hD2, 8'hEE,
        8'h70, 8'h8C, 8'h3F, 8'hA8, 8'h32, 8'hDD, 8'hF6, 8'h74,
        8'hEC, 8'h95, 8'h0B, 8'h57, 8'h5C, 8'h5B, 8'hBD, 8'h01,
        8'h24, 8'h1C, 8'h73, 8'h98, 8'h10, 8'hCC, 8'hF2, 8'hD9,
        8'h2C, 8'hE7, 8'h72, 8'h83, 8'h9B, 8'hD1, 8'h86, 8'hC9,
        8'h60, 8'h50, 8'hA3, 8'hEB, 8'h0D, 8'hB6, 8'h9E, 8'h4F,
        8'hB7, 8'h5A, 8'hC6, 8'h78, 8'hA6, 8'h12, 8'hAF, 8'hD5,
        8'h61, 8'hC3, 8'hB4, 8'h41, 8'h52, 8'h7D, 8'h8D, 8'h08,
        8'h1F, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hF7, 8'hE1,
        8'hFD, 8'h76, 8'h2F, 8'h27, 8'hB0, 8'h8B, 8'h0E, 8'hAB,
        8'hA2, 8'h6E, 8'h93, 8'h4D, 8'h69, 8'h7C, 8'h09, 8'h0A,
        8'hBF, 8'hEF, 8'hF3, 8'hC5, 8'h87, 8'h14, 8'hFE, 8'h64,
        8'hDE, 8'h2E, 8'h4B, 8'h1A, 8'h06, 8'h21, 8'h6B, 8'h66,
        8'h02, 8'hF5, 8'h92, 8'h8A, 8'h0C, 8'hB3, 8'h7E, 8'hD0,
        8'h7A, 8'h47, 8'h96, 8'hE5, 8'h26, 8'h80, 8'hAD, 8'hDF,
        8'hA1, 8'h30, 8'h37, 8'hAE, 8'h36, 8'h15, 8'h22, 8'h38,
        8'hF4, 8'hA7, 8'h45, 8'h4C, 8'h81, 8'hE9, 8'h84, 8'h97,
        8'h35, 8'hCB, 8'hCE, 8'h3C, 8'h71, 8'h11, 8'hC7, 8'h89,
        8'h75, 8'hFB, 8'hDA, 8'hF8, 8'h94, 8'h59, 8'h82, 8'hC4,
        8'hFF, 8'h49, 8'h39, 8'h67, 8'hC0, 8'hCF, 8'hD7, 8'hB8,
        8'h0F, 8'h8E, 8'h42, 8'h23, 8'h91, 8'h6C, 8'hDB, 8'hA4,
        8'h34, 8'hF1, 8'h48, 8'hC2, 8'h6F, 8'h3D, 8'h2D, 8'h40,
        8'hBE, 8'h3E, 8'hBC, 8'hC1, 8'hAA, 8'hBA, 8'h4E, 8'h55,
        8'h3B, 8'hDC, 8'h68, 8'h7F, 8'h9C, 8'hD8, 8'h4A, 8'h56,
        8'h77, 8'hA0, 8'hED, 8'h46, 8'hB5, 8'h2B, 8'h65, 8'hFA,
        8'hE3, 8'hB9, 8'hB1, 8'h9F, 8'h5E, 8'hF9, 8'hE6, 8'hB2,
        8'h31, 8'hEA, 8'h6D, 8'h5F, 8'hE4, 8'hF0, 8'hCD, 8'h88,
        8'h16, 8'h3A, 8'h58, 8'hD4, 8'h62, 8'h29, 8'h07, 8'h33,
        8'hE8, 8'h1B, 8'h05, 8'h79, 8'h90, 8'h6A, 8'h2A, 8'h9A
    };

    localparam logic [7:0] SBox2 [256] = '{
        8'h38, 8'hE8, 8'h2D, 8'hA6, 8'hCF, 8'hDE, 8'hB3, 8'hB8,
        8'hAF, 8'h60, 8'h55, 8'hC7, 8'h44, 8'h6F, 8'h6B, 8'h5B,
        8'hC3, 8'h62, 8'h33, 8'hB5, 8'h29, 8'hA0, 8'hE2, 8'hA7,
        8'hD3, 8'h91, 8'h11, 8'h06, 8'h1C, 8'hBC, 8'h36, 8'h4B,
        8'hEF, 8'h88, 8'h6C, 8'hA8, 8'h17, 8'hC4, 8'h16, 8'hF4,
        8'hC2, 8'h45, 8'hE1, 8'hD6, 8'h3F, 8'h3D, 8'h8E, 8'h98,
        8'h28, 8'h4E, 8'hF6, 8'h3E, 8'hA5, 8'hF9, 8'h0D, 8'hDF,
        8'hD8, 8'h2B, 8'h66, 8'h7A, 8'h27, 8'h2F, 8'hF1, 8'h72,
        8'h42, 8'hD4, 8'h41, 8'hC0, 8'h73, 8'h67, 8'hAC, 8'h8B,
        8'hF7, 8'hAD, 8'h80, 8'h1F, 8'hCA, 8'h2C, 8'hAA, 8'h34,
        8'hD2, 8'h0B, 8'hEE, 8'hE9, 8'h5D, 8'h94, 8'h18, 8'hF8,
        8'h57, 8'hAE, 8'h08, 8'hC5, 8'h13, 8'hCD, 8'h86, 8'hB9,
        8'hFF, 8'h7D, 8'hC1, 8'h31, 8'hF5, 8'h8A, 8'h6A, 8'hB1,
        8'hD1, 8'h20, 8'hD7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
        8'h07, 8'hDB, 8'h9D, 8'h99, 8'h61, 8'hBE, 8'hE6, 8'h59,
        8'hDD, 8'h51, 8'h90, 8'hDC, 8'h9A, 8'hA3, 8'hAB, 8'hD0,
        8'h81, 8'h0F, 8'h47, 8'h1A, 8'hE3, 8'hEC, 8'h8D, 8'hBF,
        8'h96, 8'h7B, 8'h5C, 8'hA2, 8'hA1, 8'h63, 8'h23, 8'h4D,
        8'hC8, 8'h9E, 8'h9C, 8'h3A, 8'h0C, 8'h2E, 8'hBA, 8'h6E,
        8'h9F, 8'h5A, 8'hF2, 8'h92, 8'hF3, 8'h49, 8'h78, 8'hCC,
        8'h15, 8'hFB, 8'h70, 8'h75, 8'h7F, 8'h35, 8'h10, 8'h03,
        8'h64, 8'h6D, 8'hC6, 8'h74, 8'hD5, 8'hB4, 8'hEA, 8'h09,
        8'h76, 8'h19, 8'hFE, 8'h40, 8'h12, 8'hE0, 8'hBD, 8'h05,
        8'hFA, 8'h01, 8'hF0, 8'h2A, 8'h5E, 8'hA9, 8'h56, 8'h43,
        8'h85, 8'h14, 8'h89, 8'h9B, 8'hB0, 8'hE5, 8'h48, 8'h79,
        8'h97, 8'hFC, 8'h1E, 8'h82, 8'h21, 8'h8C, 8'h1B, 8'h5F,
        8'h77, 8'h54, 8'hB2, 8'h1D, 8'h25, 8'h4F, 8'h00, 8'h46,
        8'hED, 8'h58, 8'h52, 8'hEB, 8'h7E, 8'hDA, 8'hC9, 8'hFD,
        8'h30, 8'h95, 8'h65, 8'h3C, 8'hB6, 8'hE4, 8'hBB, 8'h7C,
        8'h0E, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
        8'h37, 8'hE7, 8'h24, 8'hA4, 8'hCB, 8'h53, 8'h0A, 8'h87,
        8'hD9, 8'h4C, 8'h83, 8'h8F, 8'hCE, 8'h3B, 8'h4A, 8'hB7
    };

    // Mask m[(i + j) mod 4] selects which bits of input byte i reach output byte j.
    localparam logic [7:0] GMask [4] = '{8'hFC, 8'hF3, 8'hCF, 8'h3F};

    function automatic logic [WordW-1:0] seed_g(input logic [WordW-1:0] y);
        logic [7:0] s [4];
        logic [7:0] z [4];
        logic [1:0] m;
        s[0] = SBox1[y[7:0]];
        s[1] = SBox2[y[15:8]];
        s[2] = SBox1[y[23:16]];
        s[3] = SBox2[y[31:24]];
        for (int j = 0; j < 4; j++) begin
            z[j] = '0;
            for (int i = 0; i < 4; i++) begin
                m = 2'(i + j);
                z[j] = z[j] ^ (s[i] & GMask[m]);
            end
        end
        return {z[3], z[2], z[1], z[0]};
    endfunction

endpackage

// File: rtl/seed_dec_round.sv
// SEED round function F: key mixing, three G evaluations and the modulo-2^32 additions.
module seed_dec_round
    import seed_pkg::*;
(
    input  logic [HalfW-1:0] r_i,
    input  logic [HalfW-1:0] key_i,
    output logic [HalfW-1:0] f_o
);

    logic [WordW-1:0] c_k;
    logic [WordW-1:0] g1;
    logic [WordW-1:0] g2;
    logic [WordW-1:0] g3;

    always_comb begin
        c_k = r_i[HalfW-1:WordW] ^ key_i[HalfW-1:WordW];
        g1  = seed_g(c_k ^ r_i[WordW-1:0] ^ key_i[WordW-1:0]);
        g2  = seed_g(c_k + g1);
        g3  = seed_g(g1 + g2);
        f_o = {g2 + g3, g3};
    end

endmodule

// File: rtl/seed_dec_core.sv
// Iterative SEED block decryptor: one Feistel round per cycle, 16-entry round-key store.
// Define SEED_DEC_ENC_MODE_EN to add i_Mode, which selects forward key order (encryption).
module seed_dec_core
    import seed_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_KeyWe,
    input  logic [KeyIdxW-1:0] i_KeyAddr,
    input  logic [HalfW-1:0]   i_KeyData,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [BlockW-1:0]  i_Data,
`ifdef SEED_DEC_ENC_MODE_EN
    input  logic               i_Mode,
`endif
    output logic               o_Valid,
    input  logic               i_Ready,
    output logic [BlockW-1:0]  o_Data
);

    localparam logic [KeyIdxW-1:0] LastRound = KeyIdxW'(NumRounds - 1);

    seed_state_e        state_q;
    logic [KeyIdxW-1:0] round_q;
    logic [HalfW-1:0]   l_q;
    logic [HalfW-1:0]   r_q;
    logic               valid_q;
    logic               ready_q;
    logic [BlockW-1:0]  data_q;
`ifdef SEED_DEC_ENC_MODE_EN
    logic               mode_q;
`endif

    logic [HalfW-1:0]   key_mem [NumRounds];
    logic [KeyIdxW-1:0] key_idx;
    logic [HalfW-1:0]   round_key;
    logic [HalfW-1:0]   f_out;

    // The key store has no reset so round keys survive i_Rst.
    always_ff @(posedge i_Clk) begin
        if (i_KeyWe && state_q == StIdle) begin
            key_mem[i_KeyAddr] <= i_KeyData;
        end
    end

    always_comb begin
`ifdef SEED_DEC_ENC_MODE_EN
        key_idx = mode_q ? round_q : LastRound - round_q;
`else
        key_idx = LastRound - round_q;
`endif
        round_key = key_mem[key_idx];
    end

    seed_dec_round u_round (
        .r_i   (r_q),
        .key_i (round_key),
        .f_o   (f_out)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= StIdle;
            round_q <= '0;
            l_q     <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
`ifdef SEED_DEC_ENC_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ready_q && i_Valid) begin
                        l_q     <= i_Data[BlockW-1:HalfW];
                        r_q     <= i_Data[HalfW-1:0];
                        ready_q <= 1'b0;
                        state_q <= StRun;
`ifdef SEED_DEC_ENC_MODE_EN
                        mode_q  <= i_Mode;
`endif
                    end else begin
                        // Ready lags IDLE entry by one cycle after a completed block.
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (round_q == LastRound) begin
                        // Final round keeps the halves in place: {R16, L16}.
                        data_q  <= {l_q ^ f_out, r_q};
                        valid_q <= 1'b1;
                        round_q <= '0;
                        state_q <= StDone;
                    end else begin
                        l_q     <= r_q;
                        r_q     <= l_q ^ f_out;
                        round_q <= round_q + 4'd1;
                    end
                end
                StDone: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_Ready = ready_q;
    assign o_Valid = valid_q;
    assign o_Data  = data_q;

endmodule

// File: tb/tb_seed_dec_core.sv
// Scoreboard bench for seed_dec_core: stimulus pushes expected blocks, a monitor checks them.
module tb_seed_dec_core;
    import seed_pkg::*;

    localparam logic [127:0] Ct = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    localparam logic [127:0] Pt = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_key_we;
    logic [3:0]   i_key_addr;
    logic [63:0]  i_key_data;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
`ifdef SEED_DEC_ENC_MODE_EN
    logic         i_mode;
`endif

    seed_dec_core dut (
        .i_Clk     (clk),
        .i_Rst     (i_rst),
        .i_KeyWe   (i_key_we),
        .i_KeyAddr (i_key_addr),
        .i_KeyData (i_key_data),
        .i_Valid   (i_valid),
        .o_Ready   (o_ready),
        .i_Data    (i_data),
`ifdef SEED_DEC_ENC_MODE_EN
        .i_Mode    (i_mode),
`endif
        .o_Valid   (o_valid),
        .i_Ready   (i_ready),
        .o_Data    (o_data)
    );

    always #5 clk = ~clk;

    int unsigned  n_tests = 0;
    int unsigned  n_fail = 0;
    int unsigned  cyc = 0;
    logic [127:0] exp_q [$];
    int unsigned  acc_q [$];
    logic [127:0] stim_exp = '0;
    bit           b2b_mode = 1'b0;
    bit           have_last = 1'b0;
    int unsigned  last_acc = 0;
    logic         vld_prev = 1'b0;
    logic [63:0]  rk [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // G built from replicated S-box bytes and the SS0..SS3 word masks.
    function automatic logic [31:0] tb_g(input logic [31:0] y);
        return ({4{SBox1[y[7:0]]}}   & 32'h3FCFF3FC) ^ ({4{SBox2[y[15:8]]}}  & 32'hFC3FCFF3) ^
               ({4{SBox1[y[23:16]]}} & 32'hF3FC3FCF) ^ ({4{SBox2[y[31:24]]}} & 32'hCFF3FC3F);
    endfunction

    function automatic logic [63:0] tb_f(input logic [63:0] r, input logic [63:0] k);
        logic [31:0] t0;
        logic [31:0] t1;
        t0 = r[63:32] ^ k[63:32];
        t1 = r[31:0] ^ k[31:0];
        t1 = tb_g(t1 ^ t0);
        t0 = tb_g(t0 + t1);
        t1 = tb_g(t1 + t0);
        t0 = t0 + t1;
        return {t0, t1};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input bit enc);
        logic [63:0] l;
        logic [63:0] r;
        logic [63:0] t;
        l = blk[127:64];
        r = blk[63:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ tb_f(r, enc ? rk[i] : rk[15-i]);
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    always @(negedge clk) begin
        if (i_valid && o_ready && !i_rst) begin
            exp_q.push_back(stim_exp);
            acc_q.push_back(cyc);
            if (b2b_mode && have_last) check("accept_spacing", 128'(cyc - last_acc), 128'd19);
            last_acc  <= cyc;
            have_last <= b2b_mode;
        end
        if (o_valid && !vld_prev) begin
            if (acc_q.size() == 0) check("valid_without_accept", 128'(o_valid), 128'd0);
            else check("latency", 128'(cyc - acc_q[0]), 128'd17);
        end
        if (o_valid && i_ready && exp_q.size() > 0) begin
            check("result", o_data, exp_q.pop_front());
            void'(acc_q.pop_front());
        end
        vld_prev <= o_valid;
    end

    task automatic send(input logic [127:0] blk);
        bit done = 1'b0;
        i_data  = blk;
        i_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (o_ready) done = 1'b1;
        end
        if (!done) check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) check("drain_timeout", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  kc;
        logic [127:0] blks [3];
        logic [127:0] exps [3];
        bit           seen;

        i_rst = 1'b1; i_key_we = 1'b0; i_key_addr = '0; i_key_data = '0;
        i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
`ifdef SEED_DEC_ENC_MODE_EN
        i_mode = 1'b0;
`endif
        // Key schedule for the all-zero user key: Ki0 = G(-KCi), Ki1 = G(KCi).
        kc = 32'h9E3779B9;
        for (int i = 0; i < 16; i++) begin
            rk[i] = {tb_g(32'h0 - kc), tb_g(kc)};
            kc = {kc[30:0], kc[31]};
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_o_valid", 128'(o_valid), 128'd0);
        check("reset_o_ready", 128'(o_ready), 128'd1);
        check("reset_o_data", o_data, 128'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            i_key_we = 1'b1; i_key_addr = 4'(i); i_key_data = rk[i];
            @(posedge clk);
            #1;
        end
        i_key_we = 1'b0;

        // Basic decryption of the reference vector.
        stim_exp = Pt;
        send(Ct);
        drain();

        // Output backpressure: data and valid held, no new accept.
        i_ready = 1'b0;
        send(Ct);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        if (!seen) check("stall_valid_timeout", 128'd0, 128'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_o_valid", 128'(o_valid), 128'd1);
            check("stall_o_data", o_data, Pt);
            check("stall_o_ready", 128'(o_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_handshake_o_ready", 128'(o_ready), 128'd0);
        check("post_handshake_o_valid", 128'(o_valid), 128'd0);
        @(negedge clk);
        check("ready_rises", 128'(o_ready), 128'd1);

        // Key write while running must be ignored.
        send(Ct);
        i_key_we = 1'b1; i_key_addr = 4'd3; i_key_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        i_key_we = 1'b0;
        drain();

        // Reset during round 8 drops the block; keys remain usable.
        send(Ct);
        repeat (8) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("midrun_rst_o_valid", 128'(o_valid), 128'd0);
        check("midrun_rst_o_data", o_data, 128'd0);
        check("midrun_rst_o_ready", 128'(o_ready), 128'd1);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        send(Ct);
        drain();

        // Back-to-back blocks with i_Valid held high.
        blks[0] = Ct;          exps[0] = Pt;
        blks[1] = ~Ct;         exps[1] = model(~Ct, 1'b0);
        blks[2] = Ct ^ 128'h1; exps[2] = model(Ct ^ 128'h1, 1'b0);
        b2b_mode = 1'b1;
        i_valid  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            i_data   = blks[b];
            stim_exp = exps[b];
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (o_ready) seen = 1'b1;
            end
            if (!seen) check("b2b_accept_timeout", 128'd0, 128'd1);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        drain();
        b2b_mode = 1'b0;

`ifdef SEED_DEC_ENC_MODE_EN
        // Encrypt direction uses forward key order.
        i_mode   = 1'b1;
        stim_exp = Ct;
        send(Pt);
        i_mode = 1'b0;
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seed_dec_core.md
SEED_DEC_CORE -- requirements
Module: seed_dec_core

Interface
REQ-001 SHALL have port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_KeyWe, input, 1 bit: round-key write strobe.
REQ-004 SHALL have port i_KeyAddr, input, 4 bits: round-key index 0..15.
REQ-005 SHALL have port i_KeyData, input, 64 bits: round key Ki = {Ki0, Ki1}.
REQ-006 SHALL have port i_Valid, input, 1 bit: ciphertext block offered.
REQ-007 SHALL have port o_Ready, output, 1 bit: core can accept a block.
REQ-008 SHALL have port i_Data, input, 128 bits: ciphertext block, bits [127:64] = L, bits [63:0] = R.
REQ-009 SHALL have port o_Valid, output, 1 bit: plaintext held on o_Data.
REQ-010 SHALL have port i_Ready, input, 1 bit: sink accepts the plaintext.
REQ-011 SHALL have port o_Data, output, 128 bits: plaintext block.

Function
REQ-012 SHALL store 16 round keys of 64 bits each in an internal register file, written on the cycle where i_KeyWe=1 and the core is in IDLE.
REQ-013 SHALL ignore i_KeyWe in RUN and DONE, leaving the key store unchanged.
REQ-014 SHALL implement the state machine IDLE -> RUN on an input handshake (i_Valid & o_Ready), RUN -> DONE after the 16th round, and DONE -> IDLE on an output handshake (o_Valid & i_Ready).
REQ-015 SHALL drive o_Ready=1 only in IDLE and o_Valid=1 only in DONE.
REQ-016 SHALL give a write and an accept in the same IDLE cycle effect in this order: key write first, then block capture, so the run uses the new key.
REQ-017 SHALL perform exactly one Feistel round per RUN cycle with round counter r = 0..15, using key index 15-r.
REQ-018 SHALL compute each round as L' = R and R' = L XOR F(R, K).
REQ-019 SHALL compute F with 32-bit modulo-2^32 additions and the SEED G function, bit-exact to the SEED encryption F.
REQ-020 SHALL skip the half swap on the final round and output o_Data = {R16, L16}.
REQ-021 SHALL have a latency from the accept cycle to the first o_Valid=1 cycle of exactly 17 cycles.
REQ-022 SHALL hold o_Data stable while o_Valid=1 and i_Ready=0.
REQ-023 SHALL NOT accept a new block in the DONE-to-IDLE transition cycle; o_Ready rises on the following cycle.
REQ-024 SHALL make the round counter wrap from 15 to 0 only on the RUN -> DONE transition.

Reset
REQ-025 SHALL, on i_Rst=1 at any clock edge (including mid-RUN), enter IDLE, clear the round counter, drive o_Valid=0, o_Ready=1 on the next cycle and o_Data=0, and discard any in-flight block.
REQ-026 SHALL NOT clear the key store on reset; stored round keys persist across i_Rst.

Configuration
REQ-027 SHALL, when macro SEED_DEC_ENC_MODE_EN is defined, add port i_Mode (input, 1 bit, sampled at accept): 0 = decrypt with key index 15-r, 1 = encrypt with key index r; the datapath is otherwise identical.
REQ-028 SHALL, when SEED_DEC_ENC_MODE_EN is undefined, have no i_Mode port and perform decryption only.

Structure
REQ-029 SHALL place in a shared package seed_pkg: the round count (16), the key index width (4), the block/half/word widths (128/64/32), the state encoding type, and the G-function S-box constants.
REQ-030 SHALL implement F (3 G instances + adders) in one combinational sub-module seed_dec_round, instantiated once; control and key store remain in seed_dec_core.

Verification
REQ-031 SHALL cover this directed scenario: load keys for key=0 (RFC 4269), send ciphertext 5EBAC6E0054E166819AFF1CC6D346CDB -> o_Data = 000102030405060708090A0B0C0D0E0F, o_Valid 17 cycles after accept.
REQ-032 SHALL cover this directed scenario: same vector with i_Ready held 0 for 5 cycles -> o_Data stable, o_Valid high throughout, o_Ready=0 until 1 cycle after the handshake.
REQ-033 SHALL cover this directed scenario: i_KeyWe to index 3 with 0xFFFF_FFFF_FFFF_FFFF during RUN -> ignored; result equals REQ-031's plaintext.
REQ-034 SHALL cover this directed scenario: assert i_Rst at round 8 -> next cycle IDLE, o_Valid=0, o_Data=0; a re-sent block decrypts correctly with the keys retained.
REQ-035 SHALL cover this directed scenario: back-to-back blocks with i_Valid held high -> each accepted 19 cycles apart, results in order.
REQ-036 SHALL cover this directed scenario: with SEED_DEC_ENC_MODE_EN, i_Mode=1 and plaintext 000102...0F -> o_Data = 5EBAC6E0054E166819AFF1CC6D346CDB.
